// File: rtl/clk_div_ctrl_if.sv
// Configuration/run handshake and divided-clock outputs of clk_div_ctrl.
// master = system config logic, slave = the divider controller.
interface clk_div_ctrl_if #(
    parameter int W = 8
);
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk_out;
    logic         period_tick;
    logic [W-1:0] active_div;
    logic         busy;

    modport master (
        output en, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, clk_out, period_tick, active_div, busy
    );

    modport slave (
        input  en, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, clk_out, period_tick, active_div, busy
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable 50%-duty integer clock divider with glitch-free divisor updates
// at period boundaries and start/stop sequencing.
module clk_div_ctrl #(
    parameter int W       = 8,
    parameter int RST_DIV = 25
) (
    input  logic          clk,
    input  logic          rst,
    clk_div_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_PEND = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] TWO   = W'(2);
    localparam logic [W-1:0] RST_N = W'(RST_DIV);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_n;
    logic [W-1:0] r_pend_div;
    logic         r_pend;
    logic         w_pend_nxt;
    logic         r_pos_q;
    logic         r_neg_q;
    logic         r_err;
    logic         r_tick;

    logic         w_running;
    logic         w_ready;
    logic         w_accept;
    logic         w_legal;
    logic         w_acc_legal;
    logic         w_wrap;
    logic         w_hi;
    logic [W-1:0] w_half;
    logic [W-1:0] w_thr;
    logic [W-1:0] w_nm1;

    assign w_running   = (r_state != S_IDLE);
    assign w_ready     = (r_state != S_PEND);
    assign w_accept    = bus.cfg_valid && w_ready;
    assign w_legal     = (bus.cfg_div >= TWO);
    assign w_acc_legal = w_accept && w_legal;

    // High phase covers the last H counts; odd N gets the extra half cycle from neg_q.
    assign w_half = r_n >> 1;
    assign w_thr  = r_n - w_half;
    assign w_nm1  = r_n - ONE;
    assign w_hi   = (r_cnt >= w_thr);
    assign w_wrap = w_running && (r_cnt >= w_nm1);

    // A pending divisor is consumed at the wrap; anything left over when idle is flushed to N.
    always_comb begin
        w_pend_nxt = r_pend;
        if (!w_running) begin
            w_pend_nxt = 1'b0;
        end else begin
            if (w_wrap && r_pend) begin
                w_pend_nxt = 1'b0;
            end
            if (w_acc_legal) begin
                w_pend_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (bus.en) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!bus.en)          w_state_nxt = S_STOP;
                else if (w_acc_legal) w_state_nxt = S_PEND;
            end
            S_PEND: begin
                if (!bus.en)     w_state_nxt = S_STOP;
                else if (w_wrap) w_state_nxt = S_RUN;
            end
            S_STOP: begin
                if (bus.en)      w_state_nxt = w_pend_nxt ? S_PEND : S_RUN;
                else if (w_wrap) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_n        <= RST_N;
            r_pend_div <= '0;
            r_pend     <= 1'b0;
            r_pos_q    <= 1'b0;
            r_err      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= w_accept && !w_legal;
            r_tick  <= w_wrap;
            r_pos_q <= w_running && w_hi;
            if (!w_running) begin
                r_cnt <= '0;
                if (w_acc_legal) begin
                    r_n <= bus.cfg_div;
                end else if (r_pend) begin
                    r_n <= r_pend_div;
                end
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + ONE;
                if (w_wrap && r_pend) begin
                    r_n <= r_pend_div;
                end
                if (w_acc_legal) begin
                    r_pend_div <= bus.cfg_div;
                end
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_neg_q <= 1'b0;
        end else begin
            r_neg_q <= w_running && r_n[0] && w_hi;
        end
    end

    assign bus.clk_out     = r_pos_q | r_neg_q;
    assign bus.cfg_ready   = w_ready;
    assign bus.cfg_err     = r_err;
    assign bus.period_tick = r_tick;
    assign bus.active_div  = r_n;
    assign bus.busy        = w_running;
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Runtime-programmable integer clock divider controller with a 50%-duty output for both even and odd ratios.
- Odd ratios use a dual-edge pos/neg register pair, ORed together.
- Accepts divisor changes through a valid/ready handshake and applies them only at a period boundary, so the output never glitches.
- Sequences start/stop of the divided clock.
- Sits between the system configuration logic and clock-consuming peripherals such as the 2 MHz UART/sampling domain.

Parameters:
- W, 8, width of the divisor and of the period counter.
- RST_DIV, 25, divisor loaded at reset; must be in 2..2^W-1.

Ports:
- clk  in  1  source clock.
- rst  in  1  asynchronous reset, active-high; all flops, posedge and negedge, clear on it.
- en  in  1  run request; level-sensitive.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  W  offered divisor.
- cfg_ready  out  1  controller can accept a divisor.
- cfg_err  out  1  one-cycle pulse: the offered divisor was illegal (0 or 1) and was dropped.
- clk_out  out  1  divided clock; combinational OR of pos_q and neg_q.
- period_tick  out  1  one-cycle pulse on the posedge where the counter wraps N-1 -> 0.
- active_div  out  W  divisor currently in effect (N).
- busy  out  1  high in RUN, PEND and STOP.

Behaviour:
- Reset values:
  - Outputs: cnt=0, N=RST_DIV, pend_div=0, state=IDLE, pos_q=0, neg_q=0, clk_out=0, cfg_ready=1, cfg_err=0, period_tick=0, busy=0.
- States:
  - IDLE: counter held at 0, clk_out=0.
  - RUN: counting.
  - PEND: counting, with a new divisor waiting for the wrap.
  - STOP: finishing the current period before halting.
- Counter, in RUN/PEND/STOP:
  - cnt <= (cnt >= N-1) ? 0 : cnt+1.
  - Wrap means cnt >= N-1 at a posedge; period_tick=1 in the following cycle.
- Output generation:
  - H = N >> 1.
  - pos_q (posedge) <= running && cnt >= N-H.
  - neg_q (negedge) <= running && N[0] && cnt >= N-H. It samples the same cnt half a cycle later.
  - Even N: neg_q stays 0; high time = N/2 clk periods.
  - Odd N: high time = H+0.5 periods; low time = H+0.5 periods.
  - Output period is exactly N clk periods.
- Transitions:
  - IDLE -> RUN when en=1. cnt starts at 0 on the next posedge, and the first clk_out rising edge follows N-H+1 posedges.
  - RUN -> PEND when cfg_valid && cfg_ready && cfg_div >= 2: pend_div <= cfg_div.
  - PEND -> RUN on wrap: N <= pend_div together with cnt <= 0. The new ratio governs the very next period.
  - RUN/PEND -> STOP when en=0. A pending divisor is kept and applied at the wrap.
  - STOP -> IDLE on wrap. cnt stays 0 afterward; pos_q/neg_q fall naturally because cnt=0 < N-H.
  - STOP -> RUN if en returns to 1 before the wrap; no interruption.
- Divisor changes in IDLE: a legal cfg is written directly to N in the accept cycle; the state stays IDLE.
- Handshake:
  - cfg_ready = 0 only in PEND; a second request is back-pressured until the wrap.
  - Accept occurs on cfg_valid && cfg_ready.
  - An illegal cfg_div (0 or 1) is still accepted (consumed); cfg_err pulses the next cycle and N is unchanged.
- Simultaneous events:
  - Accept in the same cycle as a wrap in RUN: the wrap uses the old N; the new divisor goes to PEND and applies at the next wrap.
  - en falling in the same cycle as an accept: the accept is honoured and the state becomes STOP with the divisor pending.
- active_div reflects N after each update.
- Asynchronous rst mid-period forces clk_out low immediately; no runt protection is required on reset.
- Arithmetic: cnt is W bits, and comparisons are unsigned. N = 2^W-1 must not overflow.

Test Plan:
- Reset, en=1, default 25 -> clk_out period 25 clk; high 12.5 clk (pos+neg); period_tick every 25 cycles; active_div=25.
- In IDLE write cfg_div=4, then en=1 -> period 4, high 2 clk, neg_q never 1.
- Running at 25, write cfg_div=6 mid-period (cnt=10) -> cfg_ready low until wrap; the current period completes at 25; the next period is 6; a second cfg_valid is held off while PEND.
- cfg_div=1 and cfg_div=0 -> cfg_err pulse each; active_div unchanged; output undisturbed.
- Running at 7, drop en at cnt=2 -> the period finishes at cnt 6; busy falls; clk_out stays 0. Re-raise en at cnt=4 in a second run -> no gap in output.
- Assert rst at cnt=20 with N=25 -> clk_out=0 immediately. After release: N=25, state IDLE, cfg_ready=1.
